// File: rtl/cmd_line_assembler.sv
// cmd_line_assembler
//   Packs a byte-serial ASCII stream into one right-aligned word per line. This
//   is the same layout as a Verilog string literal. On a terminator the line is
//   presented with a one-cycle o_rdy pulse, together with a saturated decimal
//   value and an "all digits" flag. Lines longer than O_A_NUM_ASCII_CHARS are
//   discarded, and a one-cycle o_err pulse reports the discard.
//
// Ports
//   i_clk        clock, rising edge
//   i_reset_n    asynchronous active-low reset
//   i_valid      i_char is valid this cycle
//   i_char       ASCII character
//   o_ready      a char is consumed when i_valid & o_ready
//   o_a          last emitted line, right-aligned, zero-filled on the left
//   o_u          decimal value of the last emitted line, saturated
//   o_num_valid  last emitted line consisted only of digits
//   o_rdy        one-cycle pulse: o_a/o_u/o_num_valid hold a new line
//   o_err        one-cycle pulse: an overflowed line was discarded
module cmd_line_assembler #(
  parameter int         O_A_NUM_ASCII_CHARS = 7,
  parameter int         O_A_NUM_BITS        = O_A_NUM_ASCII_CHARS * 8,
  parameter int         O_U_NUM_BITS        = 4,
  parameter logic [7:0] TERM_CHAR           = 8'h0D,
  parameter logic [7:0] CLEAR_CHAR          = 8'h1B
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic                    i_valid,
  input  logic [7:0]              i_char,
  output logic                    o_ready,
  output logic [O_A_NUM_BITS-1:0] o_a,
  output logic [O_U_NUM_BITS-1:0] o_u,
  output logic                    o_num_valid,
  output logic                    o_rdy,
  output logic                    o_err
);

  localparam int CNT_W = $clog2(O_A_NUM_ASCII_CHARS + 1);
  // acc*10 + 9 is always below 16*2**O_U_NUM_BITS, so 4 extra bits are enough.
  localparam int ACC_W = (O_U_NUM_BITS + 4 > 8) ? O_U_NUM_BITS + 4 : 8;
  localparam logic [CNT_W-1:0]        CNT_MAX = CNT_W'(O_A_NUM_ASCII_CHARS);
  localparam logic [O_U_NUM_BITS-1:0] U_MAX   = '1;

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_DROP    = 2'd1,
    S_EMIT    = 2'd2,
    S_GAP     = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [O_A_NUM_BITS-1:0] line_q, line_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [O_U_NUM_BITS-1:0] acc_q, acc_d;
  logic                    all_dig_q, all_dig_d;
  // Marks the EMIT slot as carrying a discarded line. Discarded lines and good
  // lines therefore share the same two-cycle pulse/gap timing.
  logic                    err_q, err_d;
  logic [O_A_NUM_BITS-1:0] o_a_q, o_a_d;
  logic [O_U_NUM_BITS-1:0] o_u_q, o_u_d;
  logic                    o_num_valid_q, o_num_valid_d;

  logic                    accept;
  logic                    is_print;
  logic                    is_digit;
  logic                    clear_line;
  logic [ACC_W-1:0]        acc_wide;
  logic [O_U_NUM_BITS-1:0] acc_sat;

  assign o_ready  = i_reset_n & ((state_q == S_COLLECT) | (state_q == S_DROP));
  assign accept   = i_valid & o_ready;
  assign is_print = (i_char >= 8'h20) && (i_char <= 8'h7E);
  assign is_digit = (i_char >= 8'h30) && (i_char <= 8'h39);

  // Saturating decimal accumulate, evaluated wide before clamping.
  always_comb begin
    acc_wide = ACC_W'(acc_q) * ACC_W'(10) + ACC_W'(i_char[3:0]);
    acc_sat  = (acc_wide > ACC_W'(U_MAX)) ? U_MAX : acc_wide[O_U_NUM_BITS-1:0];
  end

  always_comb begin
    state_d       = state_q;
    line_d        = line_q;
    cnt_d         = cnt_q;
    acc_d         = acc_q;
    all_dig_d     = all_dig_q;
    err_d         = err_q;
    o_a_d         = o_a_q;
    o_u_d         = o_u_q;
    o_num_valid_d = o_num_valid_q;
    clear_line    = 1'b0;

    case (state_q)
      S_COLLECT: begin
        if (accept) begin
          if (i_char == TERM_CHAR) begin
            // An empty line (lone terminator) produces no pulse.
            if (cnt_q != '0) begin
              o_a_d         = line_q;
              o_u_d         = acc_q;
              o_num_valid_d = all_dig_q;
              err_d         = 1'b0;
              state_d       = S_EMIT;
            end
          end else if (i_char == CLEAR_CHAR) begin
            clear_line = 1'b1;
          end else if (is_print) begin
            if (cnt_q < CNT_MAX) begin
              line_d = {line_q[O_A_NUM_BITS-9:0], i_char};
              cnt_d  = cnt_q + CNT_W'(1);
              if (is_digit) begin
                acc_d = acc_sat;
              end else begin
                all_dig_d = 1'b0;
              end
            end else begin
              state_d = S_DROP;
            end
          end
        end
      end

      S_DROP: begin
        if (accept) begin
          if (i_char == CLEAR_CHAR) begin
            clear_line = 1'b1;
            state_d    = S_COLLECT;
          end else if (i_char == TERM_CHAR) begin
            clear_line = 1'b1;
            err_d      = 1'b1;
            state_d    = S_EMIT;
          end
        end
      end

      S_EMIT: begin
        clear_line = 1'b1;
        state_d    = S_GAP;
      end

      S_GAP: begin
        err_d   = 1'b0;
        state_d = S_COLLECT;
      end

      default: state_d = S_COLLECT;
    endcase

    if (clear_line) begin
      line_d    = '0;
      cnt_d     = '0;
      acc_d     = '0;
      all_dig_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q       <= S_COLLECT;
      line_q        <= '0;
      cnt_q         <= '0;
      acc_q         <= '0;
      all_dig_q     <= 1'b1;
      err_q         <= 1'b0;
      o_a_q         <= '0;
      o_u_q         <= '0;
      o_num_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      line_q        <= line_d;
      cnt_q         <= cnt_d;
      acc_q         <= acc_d;
      all_dig_q     <= all_dig_d;
      err_q         <= err_d;
      o_a_q         <= o_a_d;
      o_u_q         <= o_u_d;
      o_num_valid_q <= o_num_valid_d;
    end
  end

  assign o_a         = o_a_q;
  assign o_u         = o_u_q;
  assign o_num_valid = o_num_valid_q;
  assign o_rdy       = (state_q == S_EMIT) & ~err_q;
  assign o_err       = (state_q == S_EMIT) & err_q;

endmodule

// File: tb/tb_cmd_line_assembler.sv
// Testbench for cmd_line_assembler.
//   The testbench runs a behavioural line model, which a compare process
//   checks against the DUT on every falling edge. Directed lines come first,
//   and they also carry hand-computed literal expectations. Randomized
//   traffic follows, with random idles and random resets.
module tb_cmd_line_assembler;

  logic        clk;
  logic        rst_n;
  logic        valid;
  logic [7:0]  ch;
  logic        ready;
  logic [55:0] a;
  logic [3:0]  u;
  logic        nv;
  logic        rdy;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  cmd_line_assembler dut (
    .i_clk       (clk),
    .i_reset_n   (rst_n),
    .i_valid     (valid),
    .i_char      (ch),
    .o_ready     (ready),
    .o_a         (a),
    .o_u         (u),
    .o_num_valid (nv),
    .o_rdy       (rdy),
    .o_err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  byte unsigned m_line[$];
  bit           m_ovf   = 0;
  int           m_busy  = 0;   // cycles left before chars are accepted again
  bit           m_prdy  = 0;
  bit           m_perr  = 0;
  logic [55:0]  m_a     = '0;
  int           m_u     = 0;
  bit           m_nv    = 0;

  task automatic model_char(input logic [7:0] c);
    logic [55:0] packed_line;
    longint      value;
    bit          digits;
    int          n;
    if (c == 8'h1B) begin
      m_line.delete();
      m_ovf = 0;
    end else if (c == 8'h0D) begin
      if (m_ovf) begin
        m_perr = 1;
        m_busy = 2;
        m_line.delete();
        m_ovf = 0;
      end else if (m_line.size() > 0) begin
        n = m_line.size();
        packed_line = '0;
        value = 0;
        digits = 1;
        for (int i = 0; i < n; i++) begin
          packed_line[8*(n-1-i) +: 8] = m_line[i];
          if (m_line[i] >= 8'h30 && m_line[i] <= 8'h39)
            value = value * 10 + longint'(m_line[i] - 8'h30);
          else
            digits = 0;
        end
        m_a  = packed_line;
        m_u  = (value > 15) ? 15 : int'(value);
        m_nv = digits;
        m_prdy = 1;
        m_busy = 2;
        m_line.delete();
      end
    end else if (c >= 8'h20 && c <= 8'h7E) begin
      if (!m_ovf) begin
        if (m_line.size() < 7) m_line.push_back(c);
        else m_ovf = 1;
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_line.delete();
      m_ovf = 0; m_busy = 0; m_prdy = 0; m_perr = 0;
      m_a = '0; m_u = 0; m_nv = 0;
    end else if (m_busy > 0) begin
      m_busy--;
      m_prdy = 0;
      m_perr = 0;
    end else if (valid) begin
      model_char(ch);
    end
  end

  // One compare process, every cycle.
  always @(negedge clk) begin
    chk("o_ready",     64'(ready), 64'(rst_n && (m_busy == 0)));
    chk("o_rdy",       64'(rdy),   64'(m_prdy));
    chk("o_err",       64'(err),   64'(m_perr));
    chk("o_a",         64'(a),     64'(m_a));
    chk("o_u",         64'(u),     64'(m_u));
    chk("o_num_valid", 64'(nv),    64'(m_nv));
  end

  // ---------------- stimulus helpers (start and end on a falling edge) -------
  task automatic send(input logic [7:0] c);
    int n;
    n = 0;
    valid = 1'b1;
    ch    = c;
    while (!ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("send_timeout", 64'(n), 64'(0));
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic line_cr(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
    send(8'h0D);
  endtask

  task automatic do_reset(input int cycles, input bit check_zero);
    #2 rst_n = 1'b0;
    repeat (cycles) @(negedge clk);
    if (check_zero) begin
      chk("rst_o_a", 64'(a), 64'(0));
      chk("rst_o_u", 64'(u), 64'(0));
      chk("rst_o_num_valid", 64'(nv), 64'(0));
      chk("rst_o_rdy", 64'(rdy), 64'(0));
      chk("rst_o_err", 64'(err), 64'(0));
      chk("rst_o_ready", 64'(ready), 64'(0));
    end
    #2 rst_n = 1'b1;
    #1 chk("ready_after_release", 64'(ready), 64'(1));
    @(negedge clk);
  endtask

  function automatic logic [7:0] rand_char();
    int r;
    r = $urandom_range(0, 99);
    if (r < 35) return 8'(8'h30 + $urandom_range(0, 9));
    if (r < 60) return 8'(8'h41 + $urandom_range(0, 25));
    if (r < 75) return 8'h0D;
    if (r < 80) return 8'h1B;
    if (r < 85) return 8'($urandom_range(0, 255));
    return 8'(8'h20 + $urandom_range(0, 15));
  endfunction

  initial begin
    valid = 1'b0;
    ch    = 8'h00;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("init_o_a", 64'(a), 64'(0));
    chk("init_o_rdy", 64'(rdy), 64'(0));
    chk("init_o_ready", 64'(ready), 64'(0));
    #2 rst_n = 1'b1;
    #1 chk("init_ready_release", 64'(ready), 64'(1));
    @(negedge clk);

    // Basic command with pulse/ready timing
    line_cr("Buy");
    chk("buy_rdy", 64'(rdy), 64'(1));
    chk("buy_o_a", 64'(a), 64'h427579);
    chk("buy_nv", 64'(nv), 64'(0));
    chk("buy_ready_lo1", 64'(ready), 64'(0));
    @(negedge clk);
    chk("buy_rdy_off", 64'(rdy), 64'(0));
    chk("buy_ready_lo2", 64'(ready), 64'(0));
    @(negedge clk);
    chk("buy_ready_hi", 64'(ready), 64'(1));

    // Numeric lines
    line_cr("12");
    chk("n12_o_a", 64'(a), 64'h3132);
    chk("n12_o_u", 64'(u), 64'd12);
    chk("n12_nv", 64'(nv), 64'(1));
    line_cr("99");
    chk("n99_o_u", 64'(u), 64'd15);
    chk("n99_nv", 64'(nv), 64'(1));
    line_cr("0");
    chk("n0_o_u", 64'(u), 64'd0);
    chk("n0_nv", 64'(nv), 64'(1));

    // Overflow: discarded, error pulse, previous line held
    line_cr("AddItems");
    chk("ovf_err", 64'(err), 64'(1));
    chk("ovf_rdy", 64'(rdy), 64'(0));
    chk("ovf_o_a_held", 64'(a), 64'h30);
    @(negedge clk);
    chk("ovf_err_off", 64'(err), 64'(0));

    // Exact fit
    line_cr("AddItem");
    chk("fit_rdy", 64'(rdy), 64'(1));
    chk("fit_o_a", 64'(a), 64'h41646449_74656D);

    // Clear mid-line
    send(8'h41); send(8'h64); send(8'h1B);
    line_cr("Login");
    chk("clr_o_a", 64'(a), 64'h4C6F67696E);

    // Lone terminator
    @(negedge clk); @(negedge clk);
    send(8'h0D);
    repeat (3) begin
      chk("lone_cr_rdy", 64'(rdy), 64'(0));
      @(negedge clk);
    end

    // Non-printable char inside a line
    send(8'h42); send(8'h75); send(8'h07);
    line_cr("y");
    chk("bel_o_a", 64'(a), 64'h427579);

    // Reset mid-line, then a fresh line
    send(8'h4C); send(8'h6F); send(8'h67);
    do_reset(2, 1'b1);
    line_cr("Buy");
    chk("post_rst_o_a", 64'(a), 64'h427579);

    // Char held through the EMIT/GAP stall is consumed once
    line_cr("7");
    line_cr("8");
    chk("stall_o_a", 64'(a), 64'h38);
    chk("stall_o_u", 64'(u), 64'd8);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      int r;
      r = $urandom_range(0, 199);
      if (r < 2) do_reset($urandom_range(1, 3), 1'b0);
      else if (r < 25) @(negedge clk);
      else send(rand_char());
    end
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
